// File: rtl/brq_lsu_pkg.sv
// Shared types and encodings for the brq load/store unit controller.
// Holds the FSM state enum, RV32 funct3 codes, dmem byte-enable codes and decode helpers.
package brq_lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] BE_B0  = 3'b000;
    localparam logic [2:0] BE_B1  = 3'b001;
    localparam logic [2:0] BE_B2  = 3'b010;
    localparam logic [2:0] BE_B3  = 3'b011;
    localparam logic [2:0] BE_HHI = 3'b100;
    localparam logic [2:0] BE_HLO = 3'b101;
    localparam logic [2:0] BE_W   = 3'b110;

    // Stores only accept sb/sh/sw; loads additionally accept the unsigned forms.
    function automatic logic f3_legal(input logic store, input logic [2:0] funct3);
        logic ok;
        ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW);
        if (!store) begin
            ok = ok || (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        return ok;
    endfunction

    // funct3[1:0] carries the access size: 00 byte, 01 half, 10 word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == 2'b01) && offset[0]) || ((size == 2'b10) && (offset != 2'b00));
    endfunction

    function automatic logic [2:0] be_encode(input logic [1:0] size, input logic [1:0] offset);
        logic [2:0] be;
        unique case (size)
            2'b00:   be = {1'b0, offset};
            2'b01:   be = offset[1] ? BE_HHI : BE_HLO;
            default: be = BE_W;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/brq_load_align.sv
// Load data alignment: picks the addressed byte/half from the read word and
// sign- or zero-extends it according to funct3.
module brq_load_align
    import brq_lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[7:0];
        unique case (offset)
            2'b00: byte_lane = word[7:0];
            2'b01: byte_lane = word[15:8];
            2'b10: byte_lane = word[23:16];
            2'b11: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = word;
        unique case (funct3)
            F3_LB:   result = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  result = {24'h0, byte_lane};
            F3_LH:   result = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  result = {16'h0, half_lane};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/brq_lsu_ctrl.sv
// Load/store controller: one request at a time through IDLE -> ACCESS -> RESP,
// driving a single-cycle data memory and returning aligned, extended load data.
module brq_lsu_ctrl
    import brq_lsu_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 15
) (
    input  logic                   brq_clk,
    input  logic                   brq_rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_store,
    input  logic [2:0]             req_funct3,
    input  logic [AddrWidth+1:0]   req_addr,
    input  logic [DataWidth-1:0]   req_wdata,
    output logic                   resp_valid,
    output logic [DataWidth-1:0]   resp_rdata,
    output logic                   resp_err,
    output logic [AddrWidth-1:0]   dmem_addr,
    output logic [DataWidth-1:0]   dmem_wdata,
    output logic [2:0]             dmem_be,
    output logic                   dmem_we,
    output logic                   dmem_re,
    input  logic [DataWidth-1:0]   dmem_rdata
);

    lsu_state_e             state_q, state_d;
    logic                   store_q;
    logic [2:0]             funct3_q;
    logic [AddrWidth+1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [DataWidth-1:0]   rdata_q;

    logic                   err;
    logic [31:0]            align_result;

    assign err = !f3_legal(store_q, funct3_q) || misaligned(funct3_q[1:0], addr_q[1:0]);

    brq_load_align u_load_align (
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .word   (32'(dmem_rdata)),
        .result (align_result)
    );

    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            state_q  <= StIdle;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            // Stores and faulting requests report zero data.
            if (state_q == StAccess) begin
                rdata_q <= (!store_q && !err) ? DataWidth'(align_result) : '0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        dmem_we    = 1'b0;
        dmem_re    = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                dmem_we = store_q && !err;
                dmem_re = !store_q && !err;
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_err   = err;
                resp_rdata = rdata_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Driven from request registers so they stay put for the whole access.
    assign dmem_addr  = addr_q[AddrWidth+1:2];
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_encode(funct3_q[1:0], addr_q[1:0]);

endmodule

// File: tb/tb_brq_lsu_ctrl.sv
// Directed bench for brq_lsu_ctrl: table of load/store vectors against a small
// lane-merging memory, plus hand-written reset and request-hold sequences.
module tb_brq_lsu_ctrl;

    logic        brq_clk;
    logic        brq_rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [14:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [2:0]  dmem_be;
    logic        dmem_we;
    logic        dmem_re;
    logic [31:0] dmem_rdata;

    logic [31:0] mem [0:15];

    int n_chk;
    int n_bad;

    brq_lsu_ctrl #(
        .DataWidth (32),
        .AddrWidth (15)
    ) dut (
        .brq_clk    (brq_clk),
        .brq_rst_n  (brq_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_we    (dmem_we),
        .dmem_re    (dmem_re),
        .dmem_rdata (dmem_rdata)
    );

    initial brq_clk = 1'b0;
    always #5 brq_clk = ~brq_clk;

    assign dmem_rdata = mem[dmem_addr[3:0]];

    always @(posedge brq_clk) begin
        if (dmem_we) begin
            case (dmem_be)
                3'b000:  mem[dmem_addr[3:0]][7:0]   <= dmem_wdata[7:0];
                3'b001:  mem[dmem_addr[3:0]][15:8]  <= dmem_wdata[7:0];
                3'b010:  mem[dmem_addr[3:0]][23:16] <= dmem_wdata[7:0];
                3'b011:  mem[dmem_addr[3:0]][31:24] <= dmem_wdata[7:0];
                3'b100:  mem[dmem_addr[3:0]][31:16] <= dmem_wdata[15:0];
                3'b101:  mem[dmem_addr[3:0]][15:0]  <= dmem_wdata[15:0];
                default: mem[dmem_addr[3:0]]        <= dmem_wdata;
            endcase
        end
    end

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic        hold;
        logic        chk_be;
        logic [2:0]  be;
        logic        we;
        logic        re;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic store, input logic [2:0] f3, input logic [16:0] addr,
                                input logic [31:0] wdata, input logic hold, input logic chk_be,
                                input logic [2:0] be, input logic we, input logic re,
                                input logic err, input logic [31:0] rdata);
        vec_t v;
        v.store = store; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.hold = hold;
        v.chk_be = chk_be; v.be = be; v.we = we; v.re = re; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [14:0] a_addr;
        logic [31:0] a_wdata;
        logic [2:0]  a_be;
        logic        a_we, a_re, a_rdy, a_rv;
        logic        r_rv, r_err, r_rdy, r_we, r_re;
        logic [31:0] r_rdata;
        string       t;
        t = $sformatf("v%0d", idx);
        @(negedge brq_clk);
        req_valid  = 1'b1;
        req_store  = v.store;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        chk({t, " idle ready"}, 32'(req_ready), 32'd1);
        @(posedge brq_clk);
        #1;
        if (v.hold) begin
            req_store  = 1'b1;
            req_funct3 = 3'b010;
            req_addr   = 17'h18;
            req_wdata  = 32'h0;
        end else begin
            req_valid = 1'b0;
        end
        a_addr = dmem_addr; a_wdata = dmem_wdata; a_be = dmem_be;
        a_we = dmem_we; a_re = dmem_re; a_rdy = req_ready; a_rv = resp_valid;
        @(posedge brq_clk);
        #1;
        r_rv = resp_valid; r_err = resp_err; r_rdata = resp_rdata; r_rdy = req_ready;
        r_we = dmem_we; r_re = dmem_re;
        req_valid = 1'b0;
        @(posedge brq_clk);
        #1;
        chk({t, " access addr"}, 32'(a_addr), 32'(v.addr[16:2]));
        if (v.chk_be) chk({t, " access be"}, 32'(a_be), 32'(v.be));
        chk({t, " access we"}, 32'(a_we), 32'(v.we));
        chk({t, " access re"}, 32'(a_re), 32'(v.re));
        if (v.we) chk({t, " access wdata"}, a_wdata, v.wdata);
        chk({t, " access no resp"}, 32'(a_rv), 32'd0);
        if (v.hold) chk({t, " access ready"}, 32'(a_rdy), 32'd0);
        chk({t, " resp valid"}, 32'(r_rv), 32'd1);
        chk({t, " resp err"}, 32'(r_err), 32'(v.err));
        chk({t, " resp rdata"}, r_rdata, v.rdata);
        chk({t, " resp no mem"}, 32'({r_we, r_re}), 32'd0);
        if (v.hold) chk({t, " resp ready"}, 32'(r_rdy), 32'd0);
        chk({t, " back idle"}, 32'({req_ready, resp_valid}), 32'b10);
    endtask

    initial begin
        int pulses;
        n_chk = 0;
        n_bad = 0;
        brq_rst_n  = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        mem[4] <= 32'h80F0_7F01;
        mem[6] <= 32'h1111_1111;

        //     st  f3      addr     wdata         hold chkbe be     we re err rdata
        vecs.push_back(mk(1, 3'b001, 17'h11, 32'hFFFF_FFFF, 0, 0, 3'b000, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 3'b010, 17'h12, 32'h0,         0, 0, 3'b000, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 3'b011, 17'h10, 32'h0,         0, 0, 3'b000, 0, 0, 1, 32'h0));
        vecs.push_back(mk(1, 3'b100, 17'h10, 32'hFFFF_FFFF, 0, 0, 3'b000, 0, 0, 1, 32'h0));
        vecs.push_back(mk(0, 3'b000, 17'h13, 32'h0,         0, 1, 3'b011, 0, 1, 0, 32'hFFFF_FF80));
        vecs.push_back(mk(0, 3'b100, 17'h13, 32'h0,         1, 1, 3'b011, 0, 1, 0, 32'h0000_0080));
        vecs.push_back(mk(0, 3'b000, 17'h10, 32'h0,         0, 1, 3'b000, 0, 1, 0, 32'h0000_0001));
        vecs.push_back(mk(0, 3'b000, 17'h11, 32'h0,         0, 1, 3'b001, 0, 1, 0, 32'h0000_007F));
        vecs.push_back(mk(0, 3'b100, 17'h12, 32'h0,         0, 1, 3'b010, 0, 1, 0, 32'h0000_00F0));
        vecs.push_back(mk(0, 3'b001, 17'h12, 32'h0,         0, 1, 3'b100, 0, 1, 0, 32'hFFFF_80F0));
        vecs.push_back(mk(0, 3'b101, 17'h10, 32'h0,         0, 1, 3'b101, 0, 1, 0, 32'h0000_7F01));
        vecs.push_back(mk(0, 3'b001, 17'h10, 32'h0,         0, 1, 3'b101, 0, 1, 0, 32'h0000_7F01));
        vecs.push_back(mk(0, 3'b010, 17'h10, 32'h0,         0, 1, 3'b110, 0, 1, 0, 32'h80F0_7F01));
        vecs.push_back(mk(1, 3'b010, 17'h10, 32'hDEAD_BEEF, 0, 1, 3'b110, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 17'h10, 32'h0,         0, 1, 3'b110, 0, 1, 0, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, 3'b000, 17'h11, 32'h0000_00AA, 0, 1, 3'b001, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 17'h10, 32'h0,         0, 1, 3'b110, 0, 1, 0, 32'hDEAD_AAEF));
        vecs.push_back(mk(1, 3'b001, 17'h16, 32'h0000_1234, 0, 1, 3'b100, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b101, 17'h16, 32'h0,         0, 1, 3'b100, 0, 1, 0, 32'h0000_1234));
        vecs.push_back(mk(0, 3'b010, 17'h14, 32'h0,         0, 1, 3'b110, 0, 1, 0, 32'h1234_0000));

        #12;
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset resp", 32'({resp_valid, resp_err}), 32'd0);
        chk("reset rdata", resp_rdata, 32'h0);
        chk("reset mem strobes", 32'({dmem_we, dmem_re}), 32'd0);
        @(negedge brq_clk);
        brq_rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset pulled in the middle of a store's ACCESS cycle.
        @(negedge brq_clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 17'h18;
        req_wdata  = 32'hCAFE_F00D;
        @(posedge brq_clk);
        #1;
        req_valid = 1'b0;
        chk("rst-access we before", 32'(dmem_we), 32'd1);
        #1;
        brq_rst_n = 1'b0;
        #1;
        chk("rst-access we after", 32'(dmem_we), 32'd0);
        chk("rst-access ready", 32'(req_ready), 32'd1);
        @(negedge brq_clk);
        @(negedge brq_clk);
        brq_rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge brq_clk);
            #1;
            if (resp_valid) pulses++;
        end
        chk("rst-access no resp", 32'(pulses), 32'd0);
        chk("rst-access idle", 32'(req_ready), 32'd1);
        chk("rst-access mem kept", mem[6], 32'h1111_1111);
        run_vec(mk(0, 3'b010, 17'h18, 32'h0, 0, 1, 3'b110, 0, 1, 0, 32'h1111_1111), 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/brq_lsu_ctrl.md
BRQ_LSU_CTRL -- requirements
Module: brq_lsu_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 32, data path width.
REQ-002 SHALL have parameter AddrWidth, default 15, data-memory word-address width; the core byte address is AddrWidth+2 bits.
REQ-003 SHALL have port brq_clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port brq_rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, core load/store request valid.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_store, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3, RV32 width/sign code.
REQ-009 SHALL have port req_addr, input, AddrWidth+2, byte address.
REQ-010 SHALL have port req_wdata, input, DataWidth, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, DataWidth, extended load result (0 for stores and errors).
REQ-013 SHALL have port resp_err, output, 1, misaligned address or illegal funct3.
REQ-014 SHALL have ports dmem_addr (output, AddrWidth), dmem_wdata (output, DataWidth), dmem_be (output, 3), dmem_we (output, 1), dmem_re (output, 1) and dmem_rdata (input, DataWidth, combinational read data).

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = 1 only in IDLE; a handshake in IDLE moves to ACCESS.
REQ-016 SHALL register store flag, funct3, address and wdata on the handshake, and SHALL ignore req_* outside IDLE.
REQ-017 SHALL drive dmem_addr = registered addr[AddrWidth+1:2] in ACCESS.
REQ-018 SHALL encode dmem_be as follows: byte at offset k (0..3) -> k (3'b000..3'b011); half at offset 2 -> 3'b100; half at offset 0 -> 3'b101; word -> 3'b110.
REQ-019 SHALL treat funct3 as legal only for 000/001/010 (stores) and 000/001/010/100/101 (loads); any other value SHALL set the error.
REQ-020 SHALL flag a request as misaligned when it is a half at an odd offset or a word at a nonzero offset.
REQ-021 SHALL, for a legal aligned store in ACCESS, assert dmem_we for exactly that one cycle with dmem_wdata = registered wdata; the memory performs lane merging.
REQ-022 SHALL, for a legal aligned load in ACCESS, assert dmem_re and capture dmem_rdata at the end of ACCESS.
REQ-023 SHALL assert neither dmem_we nor dmem_re in ACCESS for an erroneous request, and SHALL drive dmem_we = dmem_re = 0 in IDLE and RESP.
REQ-024 SHALL, in RESP, assert resp_valid for one cycle with resp_err and resp_rdata.
REQ-025 SHALL form load data by selecting the lane by offset, then applying sign extension for 000/001 and zero extension for 100/101; lw passes the word unchanged.
REQ-026 SHALL give a latency of 2 cycles from handshake to resp_valid and a maximum throughput of one request per 3 cycles.
REQ-027 SHALL hold dmem_addr, dmem_be and dmem_wdata stable throughout ACCESS.

Reset
REQ-028 SHALL, while brq_rst_n = 0, set the FSM to IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, dmem_we = 0, dmem_re = 0, and clear all request registers.
REQ-029 SHALL abandon a transaction when reset is asserted in ACCESS or RESP: no write occurs after assertion and no resp_valid is produced.

Structure
REQ-030 SHALL place the FSM state enum, the funct3 codes and the dmem_be codes (BE_B0..BE_B3, BE_HHI, BE_HLO, BE_W) in shared package brq_lsu_pkg.
REQ-031 SHALL implement load lane selection and extension as sub-module brq_load_align, combinational, taking offset, funct3 and word, and returning a 32-bit result.

Verification
REQ-032 SHALL cover: sw addr 0x0010, data 0xDEADBEEF -> in ACCESS dmem_addr = 4, dmem_be = 110, dmem_we = 1; at +2 cycles resp_valid = 1, resp_err = 0.
REQ-033 SHALL cover: memory word 0x80F0_7F01 at word address 4; lb at 0x0013 -> resp_rdata = 0xFFFFFF80; lbu at 0x0013 -> 0x00000080; lb at 0x0010 -> 0x00000001.
REQ-034 SHALL cover: lh at 0x0012 on 0x80F0_7F01 -> 0xFFFF80F0 and dmem_be = 100; lhu at 0x0010 -> 0x00007F01 and dmem_be = 101.
REQ-035 SHALL cover: sh at 0x0011 and lw at 0x0012 -> no dmem_we/dmem_re pulse; resp_err = 1; resp_rdata = 0.
REQ-036 SHALL cover: a load with funct3 = 011 -> resp_err = 1; and a req_valid held high in ACCESS/RESP -> ignored, with req_ready = 0.
REQ-037 SHALL cover: brq_rst_n pulled low during ACCESS of sw -> dmem_we falls immediately, the memory word is unchanged, there is no resp_valid, and the FSM is in IDLE after release.
